delay_sched: RTL



---
 rtl/delay_sched_pkg.sv | 21 ++
 rtl/delay_sched_rr_pick.sv | 26 ++
 rtl/delay_sched.sv | 115 +++++++++++
 3 files changed

// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay-line scheduler: FSM state encoding and
// the round-robin pointer advance helper.
`ifndef DELAY_SCHED_PKG_SV
`define DELAY_SCHED_PKG_SV

package delay_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Pointer moves one past the port just served so that port goes last next time.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned r);
        return (idx + 1 == r) ? 0 : idx + 1;
    endfunction

endpackage

`endif

// File: rtl/delay_sched_rr_pick.sv
// Combinational round-robin selector: first set request bit scanning from
// i_ptr upward with wrap. Reusable by any scheduler that keeps its own pointer.
module rr_pick #(
    parameter  int R  = 2,
    localparam int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [R-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int i = 0; i < R; i++) begin
            if (!o_any && i_req[(int'(i_ptr) + i) % R]) begin
                o_any = 1'b1;
                o_idx = PW'((int'(i_ptr) + i) % R);
            end
        end
        o_onehot = o_any ? (R'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/delay_sched.sv
// Shares one delay-line bundle among R requesters: round-robin grant, launch
// the winner's data, wait T settle cycles, capture, then 4-phase done.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int   N    = 1,
    parameter int   R    = 2,
    parameter int   T    = 4,
    parameter logic Rval = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] data_in,
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   done,
    output logic [N-1:0]   result,
    output logic           busy,
    output logic [N-1:0]   dl_i,
    input  logic [N-1:0]   dl_o,
    output logic [1:0]     o_dbg_state
);

    localparam int PW = $clog2(R);
    localparam int CW = $clog2(T + 1);

    if (T < 1) begin : g_bad_t
        $error("delay_sched: T must be >= 1");
    end
    if (R < 2 || R > 16) begin : g_bad_r
        $error("delay_sched: R must be in 2..16");
    end

    state_t        r_state;
    logic [R-1:0]  r_gnt;
    logic [R-1:0]  r_done;
    logic [N-1:0]  r_result;
    logic          r_busy;
    logic [N-1:0]  r_dl_i;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_idx;
    logic [CW-1:0] r_cnt;

    logic [R-1:0]  w_onehot;
    logic [PW-1:0] w_idx;
    logic          w_any;
    logic [N-1:0]  w_sel_data;

    rr_pick #(.R(R)) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_sel_data = data_in[int'(w_idx)*N +: N];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_dl_i   <= {N{Rval}};
            r_ptr    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_onehot;
                        r_idx   <= w_idx;
                        r_dl_i  <= w_sel_data;
                        r_cnt   <= CW'(T - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // dl_i stays frozen here so the bundle sees a stable input for T cycles.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_result <= dl_o;
                        r_done   <= r_gnt;
                        r_state  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!req[r_idx]) begin
                        r_done  <= '0;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= PW'(next_ptr(int'(r_idx), R));
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign result      = r_result;
    assign busy        = r_busy;
    assign dl_i        = r_dl_i;
    assign o_dbg_state = r_state;

endmodule
